// File: rtl/demux_stream_if.sv
// Stream demux bundle: one producer-side port, NCH consumer-side channels.
// The slave modport is the demux itself; the master side drives it.
interface demux_stream_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;
    logic [NCH*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_stream.sv
// 1:NCH stream demultiplexer with a one-entry buffer per channel.
// Out-of-range selects are accepted, discarded and counted.
module demux_stream #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    demux_stream_if.slave       s,
    output logic                drop_err,
    output logic [7:0]          drop_cnt
);
    logic [NCH-1:0]       valid_q, valid_d;
    logic [NCH*WIDTH-1:0] data_q, data_d;
    logic                 drop_q, drop_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [NCH-1:0]       hit;
    logic                 sel_ok;
    logic                 ready_sel;
    logic                 ready;
    logic                 acc;

    always_comb begin
        hit = '0;
        for (int c = 0; c < NCH; c++) begin
            hit[c] = (s.in_sel == SELW'(c));
        end
    end

    // An out-of-range select matches no channel and is always accepted.
    assign sel_ok    = |hit;
    assign ready_sel = |(hit & (~valid_q | s.out_ready));
    assign ready     = rst_n & (sel_ok ? ready_sel : 1'b1);
    assign acc       = s.in_valid & ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int c = 0; c < NCH; c++) begin
            if (acc && hit[c]) begin
                valid_d[c]              = 1'b1;
                data_d[c*WIDTH +: WIDTH] = s.in_data;
            end else if (valid_q[c] && s.out_ready[c]) begin
                valid_d[c]              = 1'b0;
                data_d[c*WIDTH +: WIDTH] = '0;
            end
        end
    end

    assign drop_d = acc & ~sel_ok;
    assign cnt_d  = (drop_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s.in_ready  = ready;
    assign s.out_valid = valid_q;
    assign s.out_data  = data_q;
    assign drop_err    = drop_q;
    assign drop_cnt    = cnt_q;
endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: a 4-channel and a 3-channel instance.
// The 3-channel instance exercises out-of-range drops.
module tb_demux_stream;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux_stream_if #(.WIDTH(8), .NCH(4), .SELW(2)) ia ();
    demux_stream_if #(.WIDTH(8), .NCH(3), .SELW(2)) ib ();

    logic       a_err, b_err;
    logic [7:0] a_cnt, b_cnt;

    demux_stream #(.WIDTH(8), .NCH(4), .SELW(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .s(ia.slave),
        .drop_err(a_err), .drop_cnt(a_cnt)
    );
    demux_stream #(.WIDTH(8), .NCH(3), .SELW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s(ib.slave),
        .drop_err(b_err), .drop_cnt(b_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [1:0] sel, input logic [7:0] d);
        ia.in_valid = 1'b1;
        ia.in_sel   = sel;
        ia.in_data  = d;
        #1;
        chk("push_a_ready", {31'd0, ia.in_ready}, 32'd1);
        step();
        ia.in_valid = 1'b0;
    endtask

    logic [7:0] q[4][$];
    logic       exp_rdy;
    logic       acc;
    logic [7:0] dd;

    initial begin
        rst_n = 1'b0;
        ia.in_valid = 1'b1; ia.in_sel = '0; ia.in_data = 8'h11;
        ia.out_ready = '0;
        ib.in_valid = 1'b1; ib.in_sel = 2'd3; ib.in_data = 8'h22;
        ib.out_ready = '0;
        #1;
        chk("t1_a_ready", {31'd0, ia.in_ready}, 32'd0);
        chk("t1_b_ready", {31'd0, ib.in_ready}, 32'd0);
        step();
        step();
        chk("t1_valid", {28'd0, ia.out_valid}, 32'd0);
        chk("t1_data", ia.out_data, 32'd0);
        chk("t1_err", {31'd0, b_err}, 32'd0);
        chk("t1_cnt", {24'd0, b_cnt}, 32'd0);
        rst_n = 1'b1;
        ia.in_valid = 1'b0;
        ib.in_valid = 1'b0;
        step();

        // T2 routing and backpressure
        for (int i = 0; i < 4; i++) push_a(2'(i), 8'hA0 + 8'(i));
        chk("t2_valid", {28'd0, ia.out_valid}, 32'hF);
        chk("t2_data", ia.out_data, 32'hA3A2A1A0);
        ia.in_valid = 1'b1; ia.in_sel = 2'd2; ia.in_data = 8'h99;
        #1;
        chk("t2_bp_ready", {31'd0, ia.in_ready}, 32'd0);
        step();
        ia.in_valid = 1'b0;
        chk("t2_bp_data", ia.out_data, 32'hA3A2A1A0);

        // T3 pass-through on channel 1
        ia.out_ready = 4'hF;
        step();
        chk("t3_drained", {28'd0, ia.out_valid}, 32'd0);
        ia.out_ready = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            push_a(2'd1, 8'h10 + 8'(k));
            chk("t3_v1", {31'd0, ia.out_valid[1]}, 32'd1);
            chk("t3_d1", {24'd0, ia.out_data[15:8]}, 32'h10 + k);
        end
        step();
        chk("t3_empty", {28'd0, ia.out_valid}, 32'd0);

        // T4 drain zeroing on channel 3
        ia.out_ready = '0;
        push_a(2'd0, 8'h01);
        push_a(2'd1, 8'h02);
        push_a(2'd2, 8'h03);
        push_a(2'd3, 8'h5C);
        chk("t4_full", ia.out_data, 32'h5C030201);
        ia.out_ready = 4'b1000;
        step();
        ia.out_ready = '0;
        chk("t4_valid", {28'd0, ia.out_valid}, 32'h7);
        chk("t4_data", ia.out_data, 32'h00030201);

        // T5 drops on the 3-channel instance
        ib.in_valid = 1'b1; ib.in_sel = 2'd0; ib.in_data = 8'h77;
        step();
        ib.in_sel = 2'd3; ib.in_data = 8'hFF;
        #1;
        chk("t5_ready", {31'd0, ib.in_ready}, 32'd1);
        step();
        ib.in_valid = 1'b0;
        chk("t5_err", {31'd0, b_err}, 32'd1);
        chk("t5_cnt1", {24'd0, b_cnt}, 32'd1);
        chk("t5_valid", {29'd0, ib.out_valid}, 32'h1);
        chk("t5_data", {8'd0, ib.out_data}, 32'h77);
        step();
        chk("t5_err_off", {31'd0, b_err}, 32'd0);
        ib.in_valid = 1'b1;
        repeat (300) step();
        ib.in_valid = 1'b0;
        chk("t5_sat", {24'd0, b_cnt}, 32'd255);
        step();
        chk("t5_err_end", {31'd0, b_err}, 32'd0);
        chk("t5_sat_hold", {24'd0, b_cnt}, 32'd255);

        // T6 random traffic with a mid-stream reset
        ia.out_ready = 4'hF;
        step();
        ia.out_ready = '0;
        for (int n = 0; n < 200; n++) begin
            rst_n        = (n != 100);
            ia.in_valid  = 1'($urandom_range(0, 1));
            ia.in_sel    = 2'($urandom_range(0, 3));
            ia.in_data   = 8'($urandom);
            ia.out_ready = 4'($urandom);
            #1;
            exp_rdy = rst_n &&
                      (q[ia.in_sel].size() == 0 || ia.out_ready[ia.in_sel]);
            chk("t6_ready", {31'd0, ia.in_ready}, {31'd0, exp_rdy});
            acc = ia.in_valid && exp_rdy;
            for (int c = 0; c < 4; c++) begin
                chk("t6_valid", {31'd0, ia.out_valid[c]},
                    {31'd0, q[c].size() != 0});
                if (q[c].size() != 0) begin
                    chk("t6_data", {24'd0, ia.out_data[c*8 +: 8]},
                        {24'd0, q[c][0]});
                    if (ia.out_ready[c] && rst_n) dd = q[c].pop_front();
                end
            end
            if (acc) q[ia.in_sel].push_back(ia.in_data);
            step();
            if (n == 100) begin
                for (int c = 0; c < 4; c++) q[c].delete();
                chk("t6_rst_valid", {28'd0, ia.out_valid}, 32'd0);
                chk("t6_rst_cnt", {24'd0, b_cnt}, 32'd0);
            end
        end
        rst_n = 1'b1;
        ia.in_valid = 1'b0;
        ia.out_ready = 4'hF;
        step();
        chk("t6_final", {28'd0, ia.out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
